// File: rtl/cpu6502_pkg.sv
// ---------------------------------------------------------------------------
// cpu6502_pkg
// Shared types and constants for the 6502 interrupt/reset entry sequencer:
//   state_e  - sequencer FSM states
//   kind_e   - which entry is in progress (selects vector and pushed B bit)
//   DEF_*    - default stack page and vector low-byte addresses
//   STATUS_* - bit positions inside the P register
//   push_status() - P value as written to the stack on entry
// ---------------------------------------------------------------------------
package cpu6502_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_NMI   = 2'd1,
    KIND_IRQ   = 2'd2,
    KIND_BRK   = 2'd3
  } kind_e;

  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
  localparam logic [15:0] DEF_NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC    = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC    = 16'hFFFE;

  localparam int STATUS_I_BIT = 2;
  localparam int STATUS_B_BIT = 4;
  localparam int STATUS_U_BIT = 5;

  // The unused bit always reads back as 1 on the stack; B tells the handler
  // whether it was entered by a BRK opcode or by a hardware request.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic is_brk);
    logic [7:0] r;
    r               = p;
    r[STATUS_U_BIT] = 1'b1;
    r[STATUS_B_BIT] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// ---------------------------------------------------------------------------
// nmi_edge_detect
// Latches a rising edge on nmi until the sequencer accepts it.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   nmi     in  raw NMI request line
//   clear   in  NMI accepted this cycle
//   pending out latched NMI request
// A new edge in the same cycle as clear keeps the request pending, so an NMI
// arriving exactly as the previous one is taken is not lost.
// ---------------------------------------------------------------------------
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic clear,
  output logic pending
);

  logic nmi_prev_q;
  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = (nmi & ~nmi_prev_q) | (pend_q & ~clear);
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // prev starts high so an NMI line held high through reset is not an edge.
      nmi_prev_q <= 1'b1;
      pend_q     <= 1'b0;
    end else begin
      nmi_prev_q <= nmi;
      pend_q     <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
// Drives the 6502 bus through reset, NMI, IRQ and BRK entry: pushes PCH, PCL
// and P to the stack page, fetches the 16-bit vector and loads it into the PC.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   nmi, irq, brk      requests (nmi edge, irq level, brk decoded opcode)
//   boundary           instruction boundary; the only cycle requests are taken
//   i_flag             status I bit (masks irq)
//   pc, sp, status     values to push / stack pointer
//   data_in            memory read data
//   busy               sequencer owns the bus
//   mem_addr, read_write, data_out   bus outputs
//   sp_dec, pc_load, set_i           one-cycle pulses to the datapath
//   pc_new             new PC, valid with pc_load
// ---------------------------------------------------------------------------
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
  parameter logic [15:0] NMI_VEC    = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC    = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC    = DEF_IRQ_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk,
  input  logic        boundary,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic [7:0]  status,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        read_write,
  output logic [7:0]  data_out,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        set_i
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic        nmi_pend;
  logic        nmi_clear;

  // While rst is high the outputs already look like the first reset cycle,
  // so a reset in the middle of a push sequence suppresses that push at once.
  state_e      state_eff;
  kind_e       kind_eff;
  logic [15:0] vector;
  logic [15:0] stack_addr;

  assign state_eff  = rst ? ST_VEC_LO  : state_q;
  assign kind_eff   = rst ? KIND_RESET : kind_q;
  assign stack_addr = {STACK_PAGE, sp};

  nmi_edge_detect u_nmi_edge_detect (
    .clk     (clk),
    .rst     (rst),
    .nmi     (nmi),
    .clear   (nmi_clear),
    .pending (nmi_pend)
  );

  always_comb begin
    unique case (kind_eff)
      KIND_RESET: vector = RST_VEC;
      KIND_NMI:   vector = NMI_VEC;
      default:    vector = IRQ_VEC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_VEC_LO;
      kind_q   <= KIND_RESET;
      vec_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  // Next-state logic: arbitration at the boundary, then a fixed walk.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    kind_d    = kind_q;
    nmi_clear = 1'b0;
    vec_lo_d  = (state_eff == ST_VEC_LO) ? data_in : vec_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (boundary) begin
          if (nmi_pend) begin
            kind_d    = KIND_NMI;
            state_d   = ST_PUSH_PCH;
            nmi_clear = 1'b1;
          end else if (irq & ~i_flag) begin
            kind_d  = KIND_IRQ;
            state_d = ST_PUSH_PCH;
          end else if (brk) begin
            kind_d  = KIND_BRK;
            state_d = ST_PUSH_PCH;
          end
        end
      end
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      ST_PUSH_P:   state_d = ST_VEC_LO;
      ST_VEC_LO:   state_d = ST_VEC_HI;
      ST_VEC_HI:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output logic: purely from state, kind and registered/datapath values.
  // sp has already been decremented by the time of the next push, so every
  // push uses the live sp.
  always_comb begin
    busy       = 1'b1;
    mem_addr   = 16'h0000;
    read_write = 1'b0;
    data_out   = 8'h00;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    unique case (state_eff)
      ST_IDLE: busy = 1'b0;
      ST_PUSH_PCH: begin
        mem_addr   = stack_addr;
        read_write = 1'b1;
        data_out   = pc[15:8];
        sp_dec     = 1'b1;
      end
      ST_PUSH_PCL: begin
        mem_addr   = stack_addr;
        read_write = 1'b1;
        data_out   = pc[7:0];
        sp_dec     = 1'b1;
      end
      ST_PUSH_P: begin
        mem_addr   = stack_addr;
        read_write = 1'b1;
        data_out   = push_status(status, kind_eff == KIND_BRK);
        sp_dec     = 1'b1;
      end
      ST_VEC_LO: mem_addr = vector;
      ST_VEC_HI: begin
        mem_addr = vector + 16'd1;
        pc_load  = 1'b1;
        set_i    = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign pc_new = {data_in, vec_lo_q};

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, nmi, irq, brk, boundary, i_flag;
  logic [15:0] pc;
  logic [7:0]  sp, status, data_in;
  logic        busy, read_write, sp_dec, pc_load, set_i;
  logic [15:0] mem_addr, pc_new;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .nmi        (nmi),
    .irq        (irq),
    .brk        (brk),
    .boundary   (boundary),
    .i_flag     (i_flag),
    .pc         (pc),
    .sp         (sp),
    .status     (status),
    .data_in    (data_in),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .read_write (read_write),
    .data_out   (data_out),
    .sp_dec     (sp_dec),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .set_i      (set_i)
  );

  // ---------------- memory model: RAM plus six vector bytes at FFFA..FFFF
  logic [7:0]  ram [0:65535];
  logic [7:0]  vec_mem [0:5];
  int          wr_cnt = 0;
  logic [15:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];

  always_comb begin
    if (mem_addr >= 16'hFFFA) data_in = vec_mem[3'(mem_addr - 16'hFFFA)];
    else                      data_in = ram[mem_addr];
  end

  always @(posedge clk) begin
    if (read_write) begin
      ram[mem_addr]         <= data_out;
      log_addr[wr_cnt[7:0]] <= mem_addr;
      log_data[wr_cnt[7:0]] <= data_out;
      wr_cnt                <= wr_cnt + 1;
    end
  end

  // ---------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: pending NMI flag and priority rules
  bit m_pend    = 1'b0;
  bit m_nmi_lvl = 1'b1;

  task automatic set_nmi(input logic v);
    if (v && !m_nmi_lvl) m_pend = 1'b1;
    m_nmi_lvl = v;
    nmi       = v;
  endtask

  // 0 = nothing, 1 = NMI, 2 = IRQ, 3 = BRK
  function automatic int arbitrate(input bit pend, input bit irq_v, input bit i_v, input bit brk_v);
    if (pend)           return 1;
    if (irq_v && !i_v)  return 2;
    if (brk_v)          return 3;
    return 0;
  endfunction

  // One boundary with the given requests, then seven observed cycles.
  task automatic run_entry(input bit irq_v, input bit i_v, input bit brk_v,
                           input bit nmi_pre, input bit nmi_rise, input bit nmi_seq,
                           input logic [15:0] pc_v, input logic [7:0] sp_v, input logic [7:0] st_v,
                           output logic [15:0] first_rd, output logic [7:0] pushed_p);
    int          kind, w0, nw, vidx;
    logic [6:0]  busy_m, dec_m, load_m, seti_m;
    logic [15:0] vec, got_pcnew;
    logic [7:0]  exp_d [3];
    logic [7:0]  exp_sp;
    boundary = 1'b0; brk = 1'b0; irq = 1'b0;
    set_nmi(nmi_pre);
    tick();
    if (nmi_rise) begin
      set_nmi(1'b1);
      tick();
    end
    boundary = 1'b1; irq = irq_v; i_flag = i_v; brk = brk_v;
    pc = pc_v; sp = sp_v; status = st_v;
    kind = arbitrate(m_pend, irq_v, i_v, brk_v);
    if (kind == 1) m_pend = 1'b0;
    @(negedge clk);
    check("boundary_idle", busy, 0);
    w0 = wr_cnt;
    tick();
    boundary = 1'b0; brk = 1'b0; irq = 1'b0;
    busy_m = '0; dec_m = '0; load_m = '0; seti_m = '0;
    first_rd = 16'h0000; got_pcnew = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      if (i == 1 && nmi_seq) set_nmi(1'b1);
      @(negedge clk);
      busy_m[i] = busy; dec_m[i] = sp_dec; load_m[i] = pc_load; seti_m[i] = set_i;
      if (busy && !read_write && first_rd == 16'h0000) first_rd = mem_addr;
      if (pc_load) got_pcnew = pc_new;
      tick();
      if (dec_m[i]) sp = sp - 8'd1;
    end
    nw = wr_cnt - w0;
    if (kind == 0) begin
      check("idle_busy", busy_m, 0);
      check("idle_writes", nw, 0);
      check("idle_pc_load", load_m, 0);
    end else begin
      vec  = (kind == 1) ? 16'hFFFA : 16'hFFFE;
      vidx = (kind == 1) ? 0 : 4;
      check("busy_pattern", busy_m, 7'b0011111);
      check("sp_dec_pattern", dec_m, 7'b0000111);
      check("pc_load_pattern", load_m, 7'b0010000);
      check("set_i_pattern", seti_m, 7'b0010000);
      check("write_count", nw, 3);
      exp_d[0] = pc_v[15:8];
      exp_d[1] = pc_v[7:0];
      exp_d[2] = ((st_v | 8'h20) & 8'hEF) | ((kind == 3) ? 8'h10 : 8'h00);
      for (int k = 0; k < 3; k++) begin
        exp_sp = sp_v - 8'(k);
        check("push_addr", log_addr[8'(w0 + k)], {8'h01, exp_sp});
        check("push_data", log_data[8'(w0 + k)], exp_d[k]);
      end
      check("vector_fetch", first_rd, vec);
      check("pc_new", got_pcnew, {vec_mem[vidx + 1], vec_mem[vidx]});
    end
    pushed_p = (nw >= 3) ? log_data[8'(w0 + 2)] : 8'h00;
  endtask

  typedef struct {
    bit          irq_v, i_v, brk_v, nmi_rise;
    logic [15:0] pc_v;
    logic [7:0]  sp_v, st_v;
    logic [15:0] exp_vec;   // 0 = no entry expected
    logic [7:0]  exp_p;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] rd;
  logic [7:0]  pp;
  int          w1;

  initial begin
    tbl[0] = '{1, 0, 0, 0, 16'hC005, 8'hFD, 8'h81, 16'hFFFE, 8'hA1};  // plain IRQ
    tbl[1] = '{0, 0, 1, 1, 16'h1000, 8'hFF, 8'h00, 16'hFFFA, 8'h20};  // NMI beats BRK
    tbl[2] = '{0, 1, 1, 0, 16'h2002, 8'hFC, 8'h04, 16'hFFFE, 8'h34};  // BRK next
    tbl[3] = '{1, 1, 1, 0, 16'h3003, 8'h80, 8'h04, 16'hFFFE, 8'h34};  // masked IRQ, BRK
    tbl[4] = '{0, 0, 0, 0, 16'h4000, 8'hF0, 8'h00, 16'h0000, 8'h00};  // nothing
    tbl[5] = '{1, 1, 0, 0, 16'h5000, 8'hF0, 8'h04, 16'h0000, 8'h00};  // IRQ masked
    tbl[6] = '{1, 0, 0, 1, 16'h6000, 8'h40, 8'hFF, 16'hFFFA, 8'hEF};  // NMI beats IRQ
    tbl[7] = '{0, 0, 1, 0, 16'h7000, 8'h00, 8'h10, 16'hFFFE, 8'h30};  // BRK, sp wraps

    vec_mem[0] = 8'h00; vec_mem[1] = 8'h90;
    vec_mem[2] = 8'h34; vec_mem[3] = 8'h12;
    vec_mem[4] = 8'h00; vec_mem[5] = 8'hA0;

    // ---- reset with nmi held high throughout
    rst = 1'b1; nmi = 1'b1; irq = 1'b0; brk = 1'b0; boundary = 1'b0; i_flag = 1'b0;
    pc = 16'h0000; sp = 8'hFF; status = 8'h00;
    tick();
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_addr", mem_addr, 16'hFFFC);
    check("rst_rw", read_write, 0);
    check("rst_dout", data_out, 8'h00);
    check("rst_pulses", {sp_dec, pc_load, set_i}, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_c1_addr", mem_addr, 16'hFFFC);
    check("rst_c1_busy", busy, 1);
    check("rst_c1_load", pc_load, 0);
    tick();
    @(negedge clk);
    check("rst_c2_addr", mem_addr, 16'hFFFD);
    check("rst_c2_load", pc_load, 1);
    check("rst_c2_pcnew", pc_new, 16'h1234);
    check("rst_c2_seti", set_i, 1);
    tick();
    @(negedge clk);
    check("rst_done_busy", busy, 0);
    check("rst_no_writes", wr_cnt, 0);
    tick();
    run_entry(0, 0, 0, 1, 0, 0, 16'h0100, 8'hFF, 8'h00, rd, pp);  // nmi still high

    // ---- NMI edge during an IRQ push, then NMI, then nmi held high
    run_entry(1, 0, 0, 0, 0, 1, 16'hABCD, 8'hF8, 8'h01, rd, pp);
    check("irq_first_vec", rd, 16'hFFFE);
    run_entry(1, 0, 0, 1, 0, 0, 16'h1111, 8'hF5, 8'h00, rd, pp);
    check("nmi_after_seq", rd, 16'hFFFA);
    for (int i = 0; i < 3; i++) run_entry(0, 0, 0, 1, 0, 0, 16'h2222, 8'hF2, 8'h00, rd, pp);

    // ---- reset in PUSH_P
    boundary = 1'b0; irq = 1'b0; brk = 1'b0;
    set_nmi(1'b0);
    tick();
    boundary = 1'b1; irq = 1'b1; i_flag = 1'b0; pc = 16'hBEEF; sp = 8'hF0; status = 8'h00;
    tick();
    boundary = 1'b0; irq = 1'b0;
    set_nmi(1'b1);
    @(negedge clk);
    check("mid_pch_addr", mem_addr, 16'h01F0);
    check("mid_pch_data", data_out, 8'hBE);
    tick(); sp = 8'hEF;
    @(negedge clk);
    check("mid_pcl_data", data_out, 8'hEF);
    tick(); sp = 8'hEE;
    rst = 1'b1;
    tick();
    rst = 1'b0; m_pend = 1'b0;
    w1 = wr_cnt;
    @(negedge clk);
    check("mid_vec_lo_addr", mem_addr, 16'hFFFC);
    check("mid_vec_lo_busy", busy, 1);
    check("mid_vec_lo_rw", read_write, 0);
    check("mid_vec_lo_dec", sp_dec, 0);
    tick();
    @(negedge clk);
    check("mid_vec_hi_load", pc_load, 1);
    tick();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    @(negedge clk);
    check("mid_nmi_cleared", busy, 0);
    check("mid_no_more_writes", wr_cnt - w1, 0);
    check("mid_pch_kept", ram[16'h01F0], 8'hBE);
    check("mid_pcl_kept", ram[16'h01EF], 8'hEF);
    tick();

    // ---- table of single entries
    for (int r = 0; r < 8; r++) begin
      run_entry(tbl[r].irq_v, tbl[r].i_v, tbl[r].brk_v, 0, tbl[r].nmi_rise, 0,
                tbl[r].pc_v, tbl[r].sp_v, tbl[r].st_v, rd, pp);
      check("tbl_vec", rd, tbl[r].exp_vec);
      check("tbl_pushed_p", pp, tbl[r].exp_p);
    end

    // ---- IRQ masked for 20 boundaries
    w1 = wr_cnt;
    for (int i = 0; i < 20; i++)
      run_entry(1, 1, 0, 0, 0, 0, 16'($urandom), 8'($urandom), 8'($urandom), rd, pp);
    check("masked_no_writes", wr_cnt - w1, 0);

    // ---- randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      for (int v = 0; v < 6; v++) vec_mem[v] = 8'($urandom);
      run_entry(1'($urandom), 1'($urandom), 1'($urandom), 0,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                16'($urandom), 8'($urandom), 8'($urandom), rd, pp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
